io_serializer: RTL and testbench
================================

Name: io_serializer

Overview:
- Port-side transmitter that turns words written on a mem_mesh io port into a timed serial bit stream on one output pin.
- Input is a one-cycle `port_active` strobe carrying a DATA_WIDTH word, the same active/data convention as the mesh io ports.
- Output is a framed, continuously driven pin level with programmable bit timing.
- Buffers words in a small FIFO and reports free space back to the mesh through a status port.

Parameters:
- DATA_WIDTH, 16, bits per word and per frame payload.
- FIFO_DEPTH, 4, word buffer entries (power of two, >=2).
- DIV_WIDTH, 16, width of the bit-period divider.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- port_active  in  1  write strobe from mesh port, one word per high cycle
- port_data  in  DATA_WIDTH  word to transmit
- divider  in  DIV_WIDTH  bit period minus one, in clk cycles
- pin_out  out  1  serial line, registered, idle high
- busy  out  1  high while a frame is on the line or the FIFO is non-empty
- overflow  out  1  one-cycle pulse when a write is dropped
- status_active  out  1  one-cycle pulse at the end of each stop bit
- status_data  out  DATA_WIDTH  free FIFO entries, zero-extended, registered

Behaviour:
- Reset (rst_n low at a clk edge):
  - pin_out=1, busy=0, overflow=0, status_active=0, status_data=FIFO_DEPTH.
  - FIFO emptied, FSM to IDLE, bit counter and cycle counter cleared.
  - Reset mid-frame aborts the frame immediately; the pin returns high on the next cycle.
- Frame format:
  - Start bit 0, then DATA_WIDTH data bits LSB first, then stop bit 1.
  - Every bit lasts divider+1 cycles.
  - divider is latched at frame start; changes mid-frame take effect on the next frame only.
- FSM states:
  - IDLE: pin high. If the FIFO is non-empty, pop the head into the shift register, latch divider, go to START.
  - START: pin 0. After divider+1 cycles go to DATA with bit index 0.
  - DATA: pin = shift[0]. Each bit period, shift right and increment the index. After DATA_WIDTH bits go to STOP.
  - STOP: pin 1 for divider+1 cycles. At the end, pulse status_active. If the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - port_active sampled high at edge k into an empty FIFO with FSM in IDLE → pop at edge k+1 → pin_out low from edge k+1.
- FIFO write rules:
  - A write is accepted if not full, or if full and a pop occurs the same cycle.
  - A write is dropped only if the FIFO is full and there is no same-cycle pop. In that case overflow pulses high for exactly the cycle after the dropped write.
  - Simultaneous write and pop: count unchanged, order preserved.
- Counters:
  - The cycle counter wraps 0..latched divider.
  - divider=0 gives 1 cycle per bit.
  - divider=all-ones gives 2^DIV_WIDTH cycles per bit; no overflow of the counter.
- status_data:
  - Updated every cycle to FIFO_DEPTH minus the post-update count.
  - status_active marks a frame end so the mesh can poll free space.
- busy = (state != IDLE) | fifo non-empty, registered alongside the state.

Test Plan:
- Reset then idle, 20 cycles → pin_out=1 throughout, busy=0, status_data=4, no pulses.
- divider=3, write 0xA5C3 once → pin 0 for 4 cycles, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. Single status_active at cycle 72 after the frame start. busy falls after.
- divider=0, six writes on consecutive cycles k..k+5 → first popped at k+1; FIFO reaches 4 at k+4. Write at k+5 dropped with overflow pulse at k+6. Five frames transmitted back-to-back with no idle cycle, 18 cycles each.
- Full FIFO, write coincides with the STOP→START pop → write accepted, no overflow, status_data remains 0.
- Change divider from 1 to 7 during a frame's DATA state → current frame keeps 2-cycle bits; next frame uses 8-cycle bits.
- Assert rst_n low during DATA of a 0x00FF frame with 2 words queued → pin_out=1 next cycle, status_data=4, busy=0. A subsequent write transmits normally.

Source files
------------

// File: rtl/io_serializer.sv
// Serial transmitter for mem_mesh io port words: FIFO-buffered, start/data/stop
// framing with a latched per-frame bit period, free-space report on frame end.
module io_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  port_active,
  input  logic [DATA_WIDTH-1:0] port_data,
  input  logic [DIV_WIDTH-1:0]  divider,
  output logic                  pin_out,
  output logic                  busy,
  output logic                  overflow,
  output logic                  status_active,
  output logic [DATA_WIDTH-1:0] status_data
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                state, state_nx;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count, count_nx;
  logic                  full, empty, push, pop;

  logic [DATA_WIDTH-1:0] shift, shift_nx;
  logic [DIV_WIDTH-1:0]  div_lat, div_nx;
  logic [DIV_WIDTH-1:0]  cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic                  bit_end, frame_end;

  logic                  pin_d, busy_d, ovf_d, sact_d;
  logic [DATA_WIDTH-1:0] sdata_d;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign push     = port_active & (~full | pop);
  assign count_nx = count + CNT_W'(push) - CNT_W'(pop);
  assign bit_end  = (cnt == div_lat);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      shift         <= '0;
      div_lat       <= '0;
      cnt           <= '0;
      idx           <= '0;
      pin_out       <= 1'b1;
      busy          <= 1'b0;
      overflow      <= 1'b0;
      status_active <= 1'b0;
      status_data   <= DATA_WIDTH'(FIFO_DEPTH);
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      shift         <= shift_nx;
      div_lat       <= div_nx;
      cnt           <= cnt_nx;
      idx           <= idx_nx;
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      pin_out       <= pin_d;
      busy          <= busy_d;
      overflow      <= ovf_d;
      status_active <= sact_d;
      status_data   <= sdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= port_data;
  end

  always_comb begin
    state_nx  = state;
    shift_nx  = shift;
    div_nx    = div_lat;
    cnt_nx    = cnt;
    idx_nx    = idx;
    pop       = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          div_nx   = divider;
          cnt_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = shift >> 1;
          idx_nx   = idx + IDX_W'(1);
          if (idx == IDX_W'(DATA_WIDTH - 1)) state_nx = STOP;
        end else begin
          cnt_nx = cnt + DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          frame_end = 1'b1;
          cnt_nx    = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            div_nx   = divider;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + DIV_WIDTH'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from next-cycle values so they line up with the state.
  always_comb begin
    pin_d = 1'b1;
    case (state_nx)
      IDLE:    pin_d = 1'b1;
      START:   pin_d = 1'b0;
      DATA:    pin_d = shift_nx[0];
      STOP:    pin_d = 1'b1;
      default: pin_d = 1'b1;
    endcase
    busy_d  = (state_nx != IDLE) | (count_nx != '0);
    ovf_d   = port_active & full & ~pop;
    sact_d  = frame_end;
    sdata_d = DATA_WIDTH'(FIFO_DEPTH) - DATA_WIDTH'(count_nx);
  end

endmodule

// File: tb/tb_io_serializer.sv
// Directed bench for io_serializer: a frame-level model checked every cycle,
// plus hand-computed timing and bit-pattern expectations per scenario.
module tb_io_serializer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;

  logic            clk;
  logic            rst_n;
  logic            port_active;
  logic [DW-1:0]   port_data;
  logic [DIVW-1:0] divider;
  logic            pin_out;
  logic            busy;
  logic            overflow;
  logic            status_active;
  logic [DW-1:0]   status_data;

  io_serializer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .DIV_WIDTH (DIVW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_active  (port_active),
    .port_data    (port_data),
    .divider      (divider),
    .pin_out      (pin_out),
    .busy         (busy),
    .overflow     (overflow),
    .status_active(status_active),
    .status_data  (status_data)
  );

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: queue of pending words plus position within the frame on the line.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_word = '0;
  int            m_per = 1, m_len = 0, m_pos = 0;
  logic          m_pin = 1'b1, m_busy = 1'b0, m_ovf = 1'b0, m_sact = 1'b0;
  int            m_free = DEPTH;

  function automatic logic level(int pos, int per, logic [DW-1:0] w);
    int slot;
    slot = pos / per;
    if (slot == 0) return 1'b0;
    if (slot > DW) return 1'b1;
    return w[slot-1];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_len = 0; m_pos = 0;
      m_pin = 1'b1; m_busy = 1'b0; m_ovf = 1'b0; m_sact = 1'b0;
      m_free = DEPTH;
    end else begin
      m_sact = 1'b0;
      m_ovf  = 1'b0;
      if (m_len != 0) begin
        m_pos++;
        if (m_pos == m_len) begin
          m_len  = 0;
          m_sact = 1'b1;
        end
      end
      if (m_len == 0 && mq.size() != 0) begin
        m_word = mq.pop_front();
        m_per  = int'(divider) + 1;
        m_len  = (DW + 2) * m_per;
        m_pos  = 0;
      end
      if (port_active) begin
        if (mq.size() < DEPTH) mq.push_back(port_data);
        else m_ovf = 1'b1;
      end
      m_pin  = (m_len == 0) ? 1'b1 : level(m_pos, m_per, m_word);
      m_busy = (m_len != 0) || (mq.size() != 0);
      m_free = DEPTH - mq.size();
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_pin_out", {31'b0, pin_out}, {31'b0, m_pin});
      chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("model_overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("model_status_active", {31'b0, status_active}, {31'b0, m_sact});
      chk("model_status_data", {16'b0, status_data}, 32'(m_free));
    end
  end

  int pulse_at[$];
  int end_n;

  // Steps negedges numbered from start_n until busy drops, logging status pulses.
  task automatic watch(input int start_n, input int bound, input int chg_n,
                       input logic [DIVW-1:0] chg_div);
    int n;
    bit done;
    n = start_n - 1;
    done = 1'b0;
    pulse_at.delete();
    end_n = -1;
    while (!done && n < start_n + bound) begin
      @(negedge clk);
      n++;
      if (status_active) pulse_at.push_back(n);
      if (n == chg_n) divider = chg_div;
      if (!busy) begin
        done  = 1'b1;
        end_n = n;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL watch_timeout: busy still high after %0d cycles, required low", bound);
    end
  endtask

  int exp_seq[16] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
  int exp_free3[6] = '{3, 3, 2, 1, 0, 0};
  logic [DW-1:0] words[6] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};

  initial begin
    logic pins[80];
    logic sacts[80];
    logic busys[80];
    int   bad, nsact, n;
    logic ok;

    rst_n = 1'b0;
    port_active = 1'b0;
    port_data = '0;
    divider = '0;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_pin_out", {31'b0, pin_out}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_status_data", {16'b0, status_data}, 32'd4);
    chk("reset_pulses", {30'b0, overflow, status_active}, 32'd0);
    rst_n = 1'b1;

    // Idle after reset
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pin_out !== 1'b1 || busy !== 1'b0 || status_data !== 16'd4 ||
          overflow !== 1'b0 || status_active !== 1'b0) bad++;
    end
    chk("idle_bad_cycles", 32'(bad), 32'd0);

    // Single frame, divider=3
    divider = 16'd3;
    port_active = 1'b1;
    port_data = 16'hA5C3;
    @(negedge clk);
    port_active = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      pins[c] = pin_out;
      sacts[c] = status_active;
      busys[c] = busy;
    end
    ok = 1'b1;
    for (int c = 0; c < 4; c++) if (pins[c] !== 1'b0) ok = 1'b0;
    chk("t2_start_bit", {31'b0, ok}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      ok = 1'b1;
      for (int c = 0; c < 4; c++) if (pins[4 + 4*i + c] !== exp_seq[i][0]) ok = 1'b0;
      chk($sformatf("t2_data_bit%0d", i), {31'b0, ok}, 32'd1);
    end
    ok = 1'b1;
    for (int c = 68; c < 72; c++) if (pins[c] !== 1'b1) ok = 1'b0;
    chk("t2_stop_bit", {31'b0, ok}, 32'd1);
    nsact = 0;
    for (int c = 0; c < 80; c++) if (sacts[c] === 1'b1) nsact++;
    chk("t2_status_active_count", 32'(nsact), 32'd1);
    chk("t2_status_active_at72", {31'b0, sacts[72]}, 32'd1);
    chk("t2_busy_before_end", {31'b0, busys[71]}, 32'd1);
    chk("t2_busy_after_end", {31'b0, busys[72]}, 32'd0);

    // Six back-to-back writes, divider=0: sixth is dropped
    divider = 16'd0;
    for (int i = 0; i < 6; i++) begin
      port_active = 1'b1;
      port_data = words[i];
      @(negedge clk);
      chk($sformatf("t3_free_n%0d", i), {16'b0, status_data}, 32'(exp_free3[i]));
      chk($sformatf("t3_overflow_n%0d", i), {31'b0, overflow}, (i == 5) ? 32'd1 : 32'd0);
      if (i == 0) chk("t3_pin_n0", {31'b0, pin_out}, 32'd1);
      if (i == 1) chk("t3_pin_n1", {31'b0, pin_out}, 32'd0);
    end
    port_active = 1'b0;
    watch(6, 300, -1, '0);
    chk("t3_pulse_count", 32'(pulse_at.size()), 32'd5);
    chk("t3_first_pulse", 32'(pulse_at[0]), 32'd19);
    chk("t3_last_pulse", 32'(pulse_at[pulse_at.size()-1]), 32'd91);
    chk("t3_busy_end", 32'(end_n), 32'd91);

    // Full FIFO, write lands on the STOP->START pop
    for (int i = 0; i < 5; i++) begin
      port_active = 1'b1;
      port_data = words[i] ^ 16'hFFFF;
      @(negedge clk);
    end
    port_active = 1'b0;
    chk("t4_full_free", {16'b0, status_data}, 32'd0);
    repeat (14) @(negedge clk);
    port_active = 1'b1;
    port_data = 16'h5A5A;
    @(negedge clk);
    port_active = 1'b0;
    chk("t4_overflow", {31'b0, overflow}, 32'd0);
    chk("t4_free", {16'b0, status_data}, 32'd0);
    chk("t4_status_active", {31'b0, status_active}, 32'd1);
    watch(20, 400, -1, '0);
    chk("t4_pulse_count", 32'(pulse_at.size()), 32'd5);
    chk("t4_busy_end", 32'(end_n), 32'd109);

    // Divider change mid-frame applies to the next frame only
    divider = 16'd1;
    port_active = 1'b1;
    port_data = 16'hC0DE;
    @(negedge clk);
    port_data = 16'h0F0F;
    @(negedge clk);
    port_active = 1'b0;
    watch(2, 400, 10, 16'd7);
    chk("t5_pulse_count", 32'(pulse_at.size()), 32'd2);
    chk("t5_first_pulse", 32'(pulse_at[0]), 32'd37);
    chk("t5_second_pulse", 32'(pulse_at[1]), 32'd181);

    // Reset in the middle of a zero data bit with two words queued
    divider = 16'd1;
    port_data = 16'h00FF;
    port_active = 1'b1;
    @(negedge clk);
    port_data = 16'h1111;
    @(negedge clk);
    port_data = 16'h2222;
    @(negedge clk);
    port_active = 1'b0;
    n = 2;
    while (n < 21) begin
      @(negedge clk);
      n++;
    end
    chk("t6_pin_before_reset", {31'b0, pin_out}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_pin_after_reset", {31'b0, pin_out}, 32'd1);
    chk("t6_free_after_reset", {16'b0, status_data}, 32'd4);
    chk("t6_busy_after_reset", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_busy_stays_low", {31'b0, busy}, 32'd0);
    port_active = 1'b1;
    port_data = 16'h1234;
    @(negedge clk);
    port_active = 1'b0;
    watch(1, 200, -1, '0);
    chk("t6_post_reset_pulse", 32'(pulse_at[0]), 32'd37);
    chk("t6_post_reset_end", 32'(end_n), 32'd37);

    repeat (2) @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
